// File: rtl/flag_register_if.sv
// Port bundle for flag_register: ALU/flag-write/stack controls in, registered
// flags and save-stack status out.
interface flag_register_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             alu_result;
  logic                         alu_cout;
  logic                         alu_overflow;
  logic                         alu_valid;
  logic                         flag_write;
  logic                         cond_ex;
  logic                         wr_en;
  logic [3:0]                   wr_flags;
  logic                         push;
  logic                         pop;
  logic                         err_clr;
  logic                         negative;
  logic                         zero;
  logic                         cout;
  logic                         overflow;
  logic [$clog2(DEPTH+1)-1:0]   stack_count;
  logic                         stack_full;
  logic                         stack_empty;
  logic                         stack_err;

  modport master (
    output alu_result, alu_cout, alu_overflow, alu_valid, flag_write, cond_ex,
    output wr_en, wr_flags, push, pop, err_clr,
    input  negative, zero, cout, overflow,
    input  stack_count, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  alu_result, alu_cout, alu_overflow, alu_valid, flag_write, cond_ex,
    input  wr_en, wr_flags, push, pop, err_clr,
    output negative, zero, cout, overflow,
    output stack_count, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flag_register.sv
// Processor status flags {N,Z,C,V} with ALU capture, direct software write and
// a LIFO save stack for exception entry/return, plus a sticky misuse error.
module flag_register #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  flag_register_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);

  logic [3:0]    flags_r;
  logic [3:0]    flags_nxt_s;
  logic [3:0]    stack_r [(1 << IW)];
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          err_r;
  logic          err_nxt_s;
  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic          err_s;
  logic          alu_upd_s;
  logic [3:0]    alu_flags_s;
  logic [IW-1:0] push_idx_s;
  logic [IW-1:0] pop_idx_s;

  assign full_s      = (count_r == DEPTH_C);
  assign empty_s     = (count_r == ZERO_C);
  assign push_ok_s   = bus.push & ~bus.pop & ~full_s;
  assign pop_ok_s    = bus.pop & ~bus.push & ~empty_s;
  assign err_s       = (bus.push & bus.pop) | (bus.push & full_s) | (bus.pop & empty_s);
  assign alu_upd_s   = bus.alu_valid & bus.flag_write & bus.cond_ex;
  assign alu_flags_s = {bus.alu_result[WIDTH-1], (bus.alu_result == {WIDTH{1'b0}}),
                        bus.alu_cout, bus.alu_overflow};
  // Storage is indexed by occupancy; the top entry sits at count-1.
  assign push_idx_s  = IW'(count_r);
  assign pop_idx_s   = IW'(count_r - ONE_C);

  // Next-state selection for flags, stack occupancy and sticky error.
  always_comb begin
    flags_nxt_s = flags_r;
    count_nxt_s = count_r;
    err_nxt_s   = err_r;
    if (pop_ok_s) begin
      flags_nxt_s = stack_r[pop_idx_s];
    end else if (bus.wr_en) begin
      flags_nxt_s = bus.wr_flags;
    end else if (alu_upd_s) begin
      flags_nxt_s = alu_flags_s;
    end else begin
      flags_nxt_s = flags_r;
    end
    if (push_ok_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (pop_ok_s) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
    // A new error outranks a same-cycle clear.
    if (err_s) begin
      err_nxt_s = 1'b1;
    end else if (bus.err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Flag, occupancy and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r <= 4'b0000;
      count_r <= ZERO_C;
      err_r   <= 1'b0;
    end else begin
      flags_r <= flags_nxt_s;
      count_r <= count_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Save-stack storage; entries above the count are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      stack_r[push_idx_s] <= flags_r;
    end
  end

  assign bus.negative    = flags_r[3];
  assign bus.zero        = flags_r[2];
  assign bus.cout        = flags_r[1];
  assign bus.overflow    = flags_r[0];
  assign bus.stack_count = count_r;
  assign bus.stack_full  = full_s;
  assign bus.stack_empty = empty_s;
  assign bus.stack_err   = err_r;
endmodule

// File: tb/tb_flag_register.sv
// Directed self-checking bench for flag_register (WIDTH=32, DEPTH=4).
module tb_flag_register;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  flag_register_if #(.WIDTH(32), .DEPTH(4)) bus ();

  flag_register #(.WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] flags();
    return {bus.negative, bus.zero, bus.cout, bus.overflow};
  endfunction

  task automatic clear_ctrl();
    bus.alu_valid  = 1'b0;
    bus.flag_write = 1'b0;
    bus.cond_ex    = 1'b0;
    bus.wr_en      = 1'b0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.err_clr    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  task automatic alu(input logic [31:0] res, input logic c, input logic v, input logic ce);
    bus.alu_valid    = 1'b1;
    bus.flag_write   = 1'b1;
    bus.cond_ex      = ce;
    bus.alu_result   = res;
    bus.alu_cout     = c;
    bus.alu_overflow = v;
  endtask

  task automatic test_reset();
    total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags()); end
    total++; if (bus.stack_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.stack_count); end
    total++; if ({bus.stack_empty, bus.stack_full, bus.stack_err} !== 3'b100) begin bad++;
      $display("FAIL reset_status got=%b exp=100", {bus.stack_empty, bus.stack_full, bus.stack_err}); end
  endtask

  task automatic test_alu_update();
    alu(32'h0000_0000, 1'b1, 1'b0, 1'b1); step();
    total++; if (flags() !== 4'b0110) begin bad++; $display("FAIL alu_zero got=%b exp=0110", flags()); end
    alu(32'h8000_0000, 1'b0, 1'b1, 1'b0); step();
    total++; if (flags() !== 4'b0110) begin bad++; $display("FAIL alu_cond_fail got=%b exp=0110", flags()); end
    alu(32'h8000_0000, 1'b0, 1'b1, 1'b1); step();
    total++; if (flags() !== 4'b1001) begin bad++; $display("FAIL alu_neg got=%b exp=1001", flags()); end
    alu(32'h0000_0000, 1'b1, 1'b0, 1'b1); bus.flag_write = 1'b0; step();
    total++; if (flags() !== 4'b1001) begin bad++; $display("FAIL alu_no_s got=%b exp=1001", flags()); end
  endtask

  task automatic test_push_alu();
    bus.wr_en = 1'b1; bus.wr_flags = 4'b1010; step();
    total++; if (flags() !== 4'b1010) begin bad++; $display("FAIL wr_en got=%b exp=1010", flags()); end
    bus.push = 1'b1; alu(32'h0000_0000, 1'b0, 1'b0, 1'b1); step();
    total++; if (flags() !== 4'b0100) begin bad++; $display("FAIL push_alu_flags got=%b exp=0100", flags()); end
    total++; if (bus.stack_count !== 3'd1) begin bad++; $display("FAIL push_alu_count got=%0d exp=1", bus.stack_count); end
    bus.pop = 1'b1; bus.wr_en = 1'b1; bus.wr_flags = 4'b1111; step();
    total++; if (flags() !== 4'b1010) begin bad++; $display("FAIL pop_restore got=%b exp=1010", flags()); end
    total++; if (bus.stack_count !== 3'd0) begin bad++; $display("FAIL pop_count got=%0d exp=0", bus.stack_count); end
  endtask

  task automatic test_overflow();
    logic [3:0] pushed [4];
    logic [2:0] exp_cnt;
    pushed[0] = 4'b1010; pushed[1] = 4'b0001; pushed[2] = 4'b0010; pushed[3] = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      bus.push = 1'b1; bus.wr_en = 1'b1; bus.wr_flags = 4'(i + 1); step();
      exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
      total++; if (bus.stack_count !== exp_cnt) begin bad++; $display("FAIL push%0d_count got=%0d exp=%0d", i, bus.stack_count, exp_cnt); end
      total++; if (bus.stack_err !== (i == 4)) begin bad++; $display("FAIL push%0d_err got=%b exp=%b", i, bus.stack_err, (i == 4)); end
    end
    total++; if (bus.stack_full !== 1'b1) begin bad++; $display("FAIL full got=%b exp=1", bus.stack_full); end
    total++; if (flags() !== 4'b0101) begin bad++; $display("FAIL full_push_wr got=%b exp=0101", flags()); end
    bus.err_clr = 1'b1; step();
    total++; if (bus.stack_err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", bus.stack_err); end
    for (int i = 3; i >= 0; i--) begin
      bus.pop = 1'b1; step();
      total++; if (flags() !== pushed[i]) begin bad++; $display("FAIL lifo%0d got=%b exp=%b", i, flags(), pushed[i]); end
    end
    total++; if ({bus.stack_empty, bus.stack_count} !== {1'b1, 3'd0}) begin bad++;
      $display("FAIL empty got=%b/%0d exp=1/0", bus.stack_empty, bus.stack_count); end
  endtask

  task automatic test_illegal();
    bus.pop = 1'b1; bus.wr_en = 1'b1; bus.wr_flags = 4'b0101; step();
    total++; if (flags() !== 4'b0101) begin bad++; $display("FAIL pop_empty_flags got=%b exp=0101", flags()); end
    total++; if (bus.stack_err !== 1'b1) begin bad++; $display("FAIL pop_empty_err got=%b exp=1", bus.stack_err); end
    bus.pop = 1'b1; bus.err_clr = 1'b1; step();
    total++; if (bus.stack_err !== 1'b1) begin bad++; $display("FAIL err_vs_clr got=%b exp=1", bus.stack_err); end
    bus.err_clr = 1'b1; step();
    bus.push = 1'b1; step();
    bus.push = 1'b1; step();
    total++; if ({bus.stack_count, bus.stack_err} !== {3'd2, 1'b0}) begin bad++;
      $display("FAIL two_push got=%0d/%b exp=2/0", bus.stack_count, bus.stack_err); end
    bus.push = 1'b1; bus.pop = 1'b1; step();
    total++; if ({bus.stack_count, bus.stack_err} !== {3'd2, 1'b1}) begin bad++;
      $display("FAIL push_pop got=%0d/%b exp=2/1", bus.stack_count, bus.stack_err); end
  endtask

  task automatic test_async_reset();
    bus.push = 1'b1; bus.wr_en = 1'b1; bus.wr_flags = 4'b1111; step();
    total++; if ({bus.stack_count, flags()} !== {3'd3, 4'b1111}) begin bad++;
      $display("FAIL pre_rst got=%0d/%b exp=3/1111", bus.stack_count, flags()); end
    #2 rst = 1'b1;
    #1;
    total++; if ({flags(), bus.stack_count, bus.stack_empty, bus.stack_full, bus.stack_err} !== {4'b0000, 3'd0, 3'b100}) begin bad++;
      $display("FAIL async_rst got=%b/%0d/%b%b%b exp=0000/0/100", flags(), bus.stack_count,
               bus.stack_empty, bus.stack_full, bus.stack_err); end
    #1 rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_flags = 4'b0110; step();
    bus.push = 1'b1; bus.wr_en = 1'b1; bus.wr_flags = 4'b0000; step();
    total++; if (bus.stack_count !== 3'd1) begin bad++; $display("FAIL rst_push_count got=%0d exp=1", bus.stack_count); end
    bus.pop = 1'b1; step();
    total++; if ({flags(), bus.stack_count} !== {4'b0110, 3'd0}) begin bad++;
      $display("FAIL rst_pop got=%b/%0d exp=0110/0", flags(), bus.stack_count); end
  endtask

  task automatic test_back_to_back();
    alu(32'h0000_0005, 1'b0, 1'b0, 1'b1); step();
    total++; if (flags() !== 4'b0000) begin bad++; $display("FAIL b2b_0 got=%b exp=0000", flags()); end
    alu(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1); step();
    total++; if (flags() !== 4'b1011) begin bad++; $display("FAIL b2b_1 got=%b exp=1011", flags()); end
    alu(32'h0000_0000, 1'b0, 1'b1, 1'b1); step();
    total++; if (flags() !== 4'b0101) begin bad++; $display("FAIL b2b_2 got=%b exp=0101", flags()); end
    alu(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1); bus.alu_valid = 1'b0; step();
    total++; if (flags() !== 4'b0101) begin bad++; $display("FAIL b2b_invalid got=%b exp=0101", flags()); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_ctrl();
    bus.alu_result   = 32'h0000_0000;
    bus.alu_cout     = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.wr_flags     = 4'b0000;
    #3;
    test_reset();
    #9 rst = 1'b0;
    test_alu_update();
    test_push_alu();
    test_overflow();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
